decode_lut_stage: RTL and testbench

Registered, runtime-programmable instruction-pattern decoder for the NPC decode path. It holds `ENTRY_NR` entries, each with a pattern, a per-bit care mask and a micro-command word. Each incoming compressed instruction key (`{func7, func3, opcode[6:2]}`) is matched against the table and the winning micro-command is emitted through a one-deep valid/ready output register. It sits between IFU and IDU/EXU. It adds three things over a fixed table: masked matching, table writes after reset, and illegal-instruction counting.

---
 rtl/npc_decode_pkg.sv | 55 +++++
 rtl/lut_priority_match.sv | 31 +++
 rtl/decode_lut_stage.sv | 101 ++++++++++
 tb/tb_decode_lut_stage.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_decode_pkg.sv
// Shared definitions for the NPC decode LUT: micro-command field layout,
// default widths and the table entry record.
package npc_decode_pkg;

    localparam int PATTERN_LEN_DEF = 15;
    localparam int MICRO_LEN_DEF   = 14;

    // Single-bit flag positions inside the micro-command word
    localparam int REGEN = 13;
    localparam int PCJEN = 12;
    localparam int PCREN = 11;

    localparam logic [1:0] MWEN_NONE = 2'b00;
    localparam logic [1:0] MWEN_B    = 2'b01;
    localparam logic [1:0] MWEN_H    = 2'b10;
    localparam logic [1:0] MWEN_W    = 2'b11;

    localparam logic [1:0] MREN_NONE = 2'b00;
    localparam logic [1:0] MREN_B    = 2'b01;
    localparam logic [1:0] MREN_H    = 2'b10;
    localparam logic [1:0] MREN_W    = 2'b11;

    localparam logic [2:0] ALUOP_ADD = 3'd0;
    localparam logic [2:0] ALUOP_SUB = 3'd1;
    localparam logic [2:0] ALUOP_AND = 3'd2;
    localparam logic [2:0] ALUOP_OR  = 3'd3;
    localparam logic [2:0] ALUOP_XOR = 3'd4;
    localparam logic [2:0] ALUOP_SLT = 3'd5;
    localparam logic [2:0] ALUOP_SLL = 3'd6;
    localparam logic [2:0] ALUOP_SRL = 3'd7;

    localparam logic UNSIGN_N = 1'b0;
    localparam logic UNSIGN_Y = 1'b1;

    localparam logic [2:0] IMM_TYPE_R = 3'd0;
    localparam logic [2:0] IMM_TYPE_I = 3'd1;
    localparam logic [2:0] IMM_TYPE_S = 3'd2;
    localparam logic [2:0] IMM_TYPE_B = 3'd3;
    localparam logic [2:0] IMM_TYPE_J = 3'd4;
    localparam logic [2:0] IMM_TYPE_U = 3'd6;

    typedef struct packed {
        logic                       en;
        logic [PATTERN_LEN_DEF-1:0] pattern;
        logic [PATTERN_LEN_DEF-1:0] mask;
        logic [MICRO_LEN_DEF-1:0]   micro;
    } lut_entry_t;

    // Builds the compressed key from raw fields (opcode[1:0] is always 2'b11)
    function automatic logic [PATTERN_LEN_DEF-1:0] make_key(
        input logic [6:0] func7, input logic [2:0] func3, input logic [4:0] op5);
        return {func7, func3, op5};
    endfunction

endpackage

// File: rtl/lut_priority_match.sv
// Masked compare of one key against every table entry, then a
// lowest-index-wins priority encode.
module lut_priority_match #(
    parameter int PATTERN_LEN = 15,
    parameter int ENTRY_NR    = 40,
    parameter int IDX_W       = $clog2(ENTRY_NR)
) (
    input  logic [PATTERN_LEN-1:0]               key,
    input  logic [ENTRY_NR-1:0]                  en,
    input  logic [ENTRY_NR-1:0][PATTERN_LEN-1:0] pattern,
    input  logic [ENTRY_NR-1:0][PATTERN_LEN-1:0] mask,
    output logic                                 hit,
    output logic [IDX_W-1:0]                     idx
);

    logic [ENTRY_NR-1:0] match;

    for (genvar i = 0; i < ENTRY_NR; i++) begin : g_cmp
        assign match[i] = en[i] && (((key ^ pattern[i]) & mask[i]) == '0);
    end

    // Scan high to low so the last assignment is the lowest matching index
    always_comb begin
        hit = |match;
        idx = '0;
        for (int i = ENTRY_NR - 1; i >= 0; i--) begin
            if (match[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/decode_lut_stage.sv
// Programmable instruction-pattern decoder: table registers, one-deep
// valid/ready output register and a saturating illegal-key counter.
module decode_lut_stage
    import npc_decode_pkg::*;
#(
    parameter int PATTERN_LEN = PATTERN_LEN_DEF,
    parameter int MICRO_LEN   = MICRO_LEN_DEF,
    parameter int ENTRY_NR    = 40,
    parameter int IDX_W       = $clog2(ENTRY_NR),
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PATTERN_LEN-1:0] in_key,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [MICRO_LEN-1:0]   out_micro,
    output logic                   out_hit,
    output logic [IDX_W-1:0]       out_idx,
    input  logic                   flush,
    input  logic                   cfg_we,
    input  logic [IDX_W-1:0]       cfg_idx,
    input  logic                   cfg_en,
    input  logic [PATTERN_LEN-1:0] cfg_pattern,
    input  logic [PATTERN_LEN-1:0] cfg_mask,
    input  logic [MICRO_LEN-1:0]   cfg_micro,
    output logic [CNT_W-1:0]       illegal_cnt
);

    logic [ENTRY_NR-1:0]                  en_q;
    logic [ENTRY_NR-1:0][PATTERN_LEN-1:0] pat_q;
    logic [ENTRY_NR-1:0][PATTERN_LEN-1:0] mask_q;
    logic [ENTRY_NR-1:0][MICRO_LEN-1:0]   micro_q;

    logic                 m_hit;
    logic [IDX_W-1:0]     m_idx;
    logic [MICRO_LEN-1:0] m_micro;
    logic                 accept;

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Lookup reads the registered table, so a same-cycle write is not visible
    lut_priority_match #(
        .PATTERN_LEN (PATTERN_LEN),
        .ENTRY_NR    (ENTRY_NR),
        .IDX_W       (IDX_W)
    ) u_match (
        .key     (in_key),
        .en      (en_q),
        .pattern (pat_q),
        .mask    (mask_q),
        .hit     (m_hit),
        .idx     (m_idx)
    );

    assign m_micro = m_hit ? micro_q[m_idx] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q    <= '0;
            pat_q   <= '0;
            mask_q  <= '0;
            micro_q <= '0;
        end else if (cfg_we && int'(cfg_idx) < ENTRY_NR) begin
            en_q[cfg_idx]    <= cfg_en;
            pat_q[cfg_idx]   <= cfg_pattern;
            mask_q[cfg_idx]  <= cfg_mask;
            micro_q[cfg_idx] <= cfg_micro;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_hit   <= 1'b0;
            out_micro <= '0;
            out_idx   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_hit   <= m_hit;
            out_micro <= m_micro;
            out_idx   <= m_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (accept && !m_hit && illegal_cnt != '1) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_lut_stage.sv
// Scenario bench for decode_lut_stage: expected {hit, micro, idx} results are
// queued at accept time and popped when the DUT presents them.
module tb_decode_lut_stage;
    import npc_decode_pkg::*;

    localparam int PL = 15;
    localparam int ML = 14;
    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic          flush = 1'b0;
    logic          cfg_we = 1'b0;
    logic          cfg_en = 1'b0;
    logic [PL-1:0] in_key = '0;
    logic [PL-1:0] cfg_pattern = '0;
    logic [PL-1:0] cfg_mask = '0;
    logic [IW-1:0] cfg_idx = '0;
    logic [ML-1:0] cfg_micro = '0;

    logic          in_ready, out_valid, out_hit;
    logic [ML-1:0] out_micro;
    logic [IW-1:0] out_idx;
    logic [31:0]   illegal_cnt;

    logic          sat_in_ready, sat_out_valid, sat_out_hit;
    logic [ML-1:0] sat_out_micro;
    logic [IW-1:0] sat_out_idx;
    logic [2:0]    sat_cnt;

    logic [20:0] exp_q[$];
    logic [20:0] exp_r;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_lut_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_micro(out_micro), .out_hit(out_hit),
        .out_idx(out_idx), .flush(flush), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_micro(cfg_micro),
        .illegal_cnt(illegal_cnt)
    );

    decode_lut_stage #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready), .in_key(in_key),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_micro(sat_out_micro),
        .out_hit(sat_out_hit), .out_idx(sat_out_idx), .flush(flush), .cfg_we(cfg_we),
        .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
        .cfg_micro(cfg_micro), .illegal_cnt(sat_cnt)
    );

    function automatic logic [20:0] res(input logic h, input logic [13:0] m, input logic [5:0] i);
        return {h, m, i};
    endfunction

    task automatic do_write(input logic [IW-1:0] idx, input lut_entry_t e);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = idx; cfg_en = e.en;
        cfg_pattern = e.pattern; cfg_mask = e.mask; cfg_micro = e.micro;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if ({out_hit, out_micro, out_idx} !== 21'h0) begin
            n_err++; $display("FAIL reset_result: got %h want 0", {out_hit, out_micro, out_idx});
        end
        n_cmp++;
        if (illegal_cnt !== 32'd0) begin
            n_err++; $display("FAIL reset_cnt: got %0d want 0", illegal_cnt);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_miss_count;
        for (int i = 0; i <= 9; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_cmp++;
                if (out_valid !== 1'b1 || exp_q.size() == 0) begin
                    n_err++; $display("FAIL miss_valid: got valid=%b queued=%0d want valid=1", out_valid, exp_q.size());
                end else begin
                    exp_r = exp_q.pop_front();
                    if ({out_hit, out_micro, out_idx} !== exp_r) begin
                        n_err++; $display("FAIL miss_result: got %h want %h", {out_hit, out_micro, out_idx}, exp_r);
                    end
                end
            end
            if (i == 5) begin
                n_cmp++;
                if (illegal_cnt !== 32'd5) begin
                    n_err++; $display("FAIL miss_cnt5: got %0d want 5", illegal_cnt);
                end
                n_cmp++;
                if (sat_cnt !== 3'd5) begin
                    n_err++; $display("FAIL sat_cnt5: got %0d want 5", sat_cnt);
                end
                n_cmp++;
                if ({sat_out_valid, sat_in_ready, sat_out_hit, sat_out_micro, sat_out_idx} !== {2'b11, 21'h0}) begin
                    n_err++; $display("FAIL sat_result: got %h want %h",
                        {sat_out_valid, sat_in_ready, sat_out_hit, sat_out_micro, sat_out_idx}, {2'b11, 21'h0});
                end
            end
            if (i < 9) begin
                in_valid = 1'b1; in_key = PL'($urandom); out_ready = 1'b1;
                exp_q.push_back(res(1'b0, 14'h0, 6'd0));
            end else begin
                in_valid = 1'b0;
            end
        end
        n_cmp++;
        if (illegal_cnt !== 32'd9) begin
            n_err++; $display("FAIL miss_cnt9: got %0d want 9", illegal_cnt);
        end
        n_cmp++;
        if (sat_cnt !== 3'd7) begin
            n_err++; $display("FAIL sat_cnt_saturate: got %0d want 7", sat_cnt);
        end
    endtask

    task automatic test_priority;
        logic [PL-1:0] k [2];
        logic [20:0]   r [2];
        k[0] = 15'h0004; r[0] = res(1'b1, 14'h2001, 6'd1);
        k[1] = 15'h0024; r[1] = res(1'b1, 14'h1111, 6'd3);
        do_write(6'd1, '{1'b1, 15'h0004, 15'h00FF, 14'h2001});
        do_write(6'd3, '{1'b1, 15'h0004, 15'h001F, 14'h1111});
        for (int i = 0; i <= 2; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_cmp++;
                if (out_valid !== 1'b1 || exp_q.size() == 0) begin
                    n_err++; $display("FAIL prio_valid: got valid=%b queued=%0d want valid=1", out_valid, exp_q.size());
                end else begin
                    exp_r = exp_q.pop_front();
                    if ({out_hit, out_micro, out_idx} !== exp_r) begin
                        n_err++; $display("FAIL prio_result: got %h want %h", {out_hit, out_micro, out_idx}, exp_r);
                    end
                end
            end
            if (i < 2) begin
                in_valid = 1'b1; in_key = k[i]; exp_q.push_back(r[i]);
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_masked_lui;
        do_write(6'd0, '{1'b1, 15'h000D, 15'h001F, 14'h2006});
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL lui_idle: got valid=%b want 0", out_valid);
        end
        in_valid = 1'b1; in_key = 15'h7FED; out_ready = 1'b1;
        exp_q.push_back(res(1'b1, 14'h2006, 6'd0));
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            n_err++; $display("FAIL lui_latency: got valid=%b want 1", out_valid);
        end else begin
            exp_r = exp_q.pop_front();
            if ({out_hit, out_micro, out_idx} !== exp_r) begin
                n_err++; $display("FAIL lui_result: got %h want %h", {out_hit, out_micro, out_idx}, exp_r);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL lui_drain: got valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        in_valid = 1'b1; in_key = 15'h0004; out_ready = 1'b1;
        exp_q.push_back(res(1'b1, 14'h2001, 6'd1));
        @(negedge clk);
        out_ready = 1'b0; in_key = 15'h7FED;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++; $display("FAIL bp_in_ready: cycle %0d got %b want 0", c, in_ready);
            end
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || {out_hit, out_micro, out_idx} !== exp_q[0]) begin
                n_err++; $display("FAIL bp_hold: cycle %0d got valid=%b res=%h want valid=1 res=%h",
                    c, out_valid, {out_hit, out_micro, out_idx}, exp_q[0]);
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_release: got in_ready=%b want 1", in_ready);
        end
        exp_r = exp_q.pop_front();
        n_cmp++;
        if ({out_hit, out_micro, out_idx} !== exp_r) begin
            n_err++; $display("FAIL bp_result: got %h want %h", {out_hit, out_micro, out_idx}, exp_r);
        end
        exp_q.push_back(res(1'b1, 14'h2006, 6'd0));
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            n_err++; $display("FAIL bp_next_valid: got valid=%b want 1", out_valid);
        end else begin
            exp_r = exp_q.pop_front();
            if ({out_hit, out_micro, out_idx} !== exp_r) begin
                n_err++; $display("FAIL bp_next_result: got %h want %h", {out_hit, out_micro, out_idx}, exp_r);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_collision;
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 6'd2; cfg_en = 1'b1;
        cfg_pattern = 15'h000C; cfg_mask = 15'h001F; cfg_micro = 14'h2000;
        in_valid = 1'b1; in_key = 15'h000C; out_ready = 1'b1;
        exp_q.push_back(res(1'b0, 14'h0, 6'd0));
        @(negedge clk);
        cfg_we = 1'b0;
        exp_r = exp_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || {out_hit, out_micro, out_idx} !== exp_r) begin
            n_err++; $display("FAIL coll_same_cycle: got valid=%b res=%h want valid=1 res=%h",
                out_valid, {out_hit, out_micro, out_idx}, exp_r);
        end
        exp_q.push_back(res(1'b1, 14'h2000, 6'd2));
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        cfg_we = 1'b1; cfg_idx = 6'd2; cfg_micro = 14'h3FFF;
        n_cmp++;
        if (out_valid !== 1'b1 || {out_hit, out_micro, out_idx} !== exp_q[0]) begin
            n_err++; $display("FAIL coll_next_cycle: got valid=%b res=%h want valid=1 res=%h",
                out_valid, {out_hit, out_micro, out_idx}, exp_q[0]);
        end
        @(negedge clk);
        cfg_we = 1'b0;
        exp_r = exp_q.pop_front();
        n_cmp++;
        if ({out_hit, out_micro, out_idx} !== exp_r) begin
            n_err++; $display("FAIL coll_held_after_write: got %h want %h", {out_hit, out_micro, out_idx}, exp_r);
        end
        out_ready = 1'b1;
        do_write(6'd45, '{1'b1, 15'h0015, 15'h7FFF, 14'h1234});
        in_valid = 1'b1; in_key = 15'h0015;
        exp_q.push_back(res(1'b0, 14'h0, 6'd0));
        @(negedge clk);
        in_valid = 1'b0;
        exp_r = exp_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || {out_hit, out_micro, out_idx} !== exp_r) begin
            n_err++; $display("FAIL coll_idx_range: got valid=%b res=%h want valid=1 res=%h",
                out_valid, {out_hit, out_micro, out_idx}, exp_r);
        end
        @(negedge clk);
    endtask

    task automatic test_flush_reset;
        @(negedge clk);
        in_valid = 1'b1; in_key = 15'h7FED; out_ready = 1'b0;
        exp_q.push_back(res(1'b1, 14'h2006, 6'd0));
        @(negedge clk);
        flush = 1'b1; in_key = 15'h0004;
        exp_r = exp_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || {out_hit, out_micro, out_idx} !== exp_r) begin
            n_err++; $display("FAIL flush_held: got valid=%b res=%h want valid=1 res=%h",
                out_valid, {out_hit, out_micro, out_idx}, exp_r);
        end
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL flush_in_ready: got %b want 0", in_ready);
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_clear: got valid=%b want 0", out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_no_accept: got valid=%b want 0", out_valid);
        end
        in_valid = 1'b1; in_key = 15'h7FED;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL rst_pre_valid: got valid=%b want 1", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_async_drop: got valid=%b want 0", out_valid);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_key = 15'h7FED;
        exp_q.push_back(res(1'b0, 14'h0, 6'd0));
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            n_err++; $display("FAIL rst_lui_valid: got valid=%b want 1", out_valid);
        end else begin
            exp_r = exp_q.pop_front();
            if ({out_hit, out_micro, out_idx} !== exp_r) begin
                n_err++; $display("FAIL rst_lui_miss: got %h want %h", {out_hit, out_micro, out_idx}, exp_r);
            end
        end
        n_cmp++;
        if (illegal_cnt !== 32'd1) begin
            n_err++; $display("FAIL rst_cnt: got %0d want 1", illegal_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_miss_count();
        test_priority();
        test_masked_lui();
        test_backpressure();
        test_collision();
        test_flush_reset();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
